// File: rtl/enc_pkg.sv
// Shared types and helpers for the sequential priority encoder.
// Holds the FSM state type, a width helper and a reference selector.
package enc_pkg;

  localparam int MAX_N = 16;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } enc_state_e;

  // Ceil(log2(n)), usable in parameter expressions.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Highest set index of v; value for v == 0 is meaningless.
  function automatic logic [3:0] prio_idx(
    input logic [MAX_N-1:0] v
  );
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < MAX_N; i++)
      if (v[i]) r = 4'(i);
    return r;
  endfunction

endpackage

// File: rtl/prio_enc_comb.sv
// Combinational highest-index priority encoder, N lines to W bits.
// Ports: v_i request vector, idx_o winning index, any_o v_i != 0.
module prio_enc_comb
  import enc_pkg::*;
#(
  parameter int N = 4,
  localparam int W = clog2(N)
) (
  input  logic [N-1:0] v_i,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  // Later (higher) indices overwrite earlier ones, so the
  // highest set bit wins.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < N; i++)
      if (v_i[i]) idx_o = W'(i);
  end

  assign any_o = |v_i;

endmodule

// File: rtl/enc_prio_seq.sv
// Sequential priority encoder: buffers requests, issues one code
// per handshake (highest first), with a one-hot grant echo.
// Ports: clk, reset_n (async low), en/req capture, code/valid/
// grant_oh registered outputs, ready consumer accept, pending view.
module enc_prio_seq
  import enc_pkg::*;
#(
  parameter int N = 4,
  localparam int W = clog2(N)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic [W-1:0] code,
  output logic         valid,
  input  logic         ready,
  output logic [N-1:0] grant_oh,
  output logic [N-1:0] pending
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  enc_state_e   state_q, state_d;
  logic [N-1:0] pend_q, pend_d;
  logic [W-1:0] code_q, code_d;
  logic         valid_q, valid_d;
  logic [N-1:0] grant_q, grant_d;

  logic [N-1:0] set_v;
  logic [N-1:0] clr_v;
  logic [W-1:0] win_idx;
  logic         win_any;
  logic         hs;

  assign hs    = valid_q & ready;
  assign set_v = en ? req : '0;
  assign clr_v = hs ? grant_q : '0;

  // Set wins over clear: a re-requested bit stays pending.
  assign pend_d = (pend_q & ~clr_v) | set_v;

  prio_enc_comb #(
    .N (N)
  ) u_prio (
    .v_i   (pend_d),
    .idx_o (win_idx),
    .any_o (win_any)
  );

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    valid_d = valid_q;
    grant_d = grant_q;
    unique case (state_q)
      IDLE: begin
        if (win_any) begin
          code_d  = win_idx;
          grant_d = ONE << win_idx;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // No preemption: only a handshake changes the code.
        if (ready) begin
          if (win_any) begin
            code_d  = win_idx;
            grant_d = ONE << win_idx;
          end else begin
            valid_d = 1'b0;
            grant_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      grant_q <= grant_d;
    end
  end

  assign code     = code_q;
  assign valid    = valid_q;
  assign grant_oh = grant_q;
  assign pending  = pend_q;

endmodule
